// File: rtl/pe_operand_sequencer_if.sv
// Result stream from the operand sequencer to the downstream consumer.
// valid/ready: a word transfers on any rising clk edge where out_valid && out_ready; while out_valid is high and out_ready is low, out_index and out_data are held stable.
interface pe_operand_sequencer_if #(
    parameter int DATA_W = 16
);
    logic              out_valid;
    logic              out_ready;
    logic [6:0]        out_index;
    logic [DATA_W-1:0] out_data;

    modport master (
        output out_valid,
        output out_index,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_index,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/pe_operand_sequencer.sv
// Streams activation/weight pairs from two sync-read memories into one FP16 MAC PE,
// then captures one accumulated result per output neuron and offers it on a valid/ready stream.
module pe_operand_sequencer #(
    parameter int DATA_W      = 16,
    parameter int NUM_TERMS   = 400,
    parameter int NUM_OUTPUTS = 120,
    parameter int ACT_ADDR_W  = 9,
    parameter int WGT_ADDR_W  = 16,
    parameter int PE_LATENCY  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  act_rd_en,
    output logic [ACT_ADDR_W-1:0] act_addr,
    input  logic [DATA_W-1:0]     act_data,
    output logic                  wgt_rd_en,
    output logic [WGT_ADDR_W-1:0] wgt_addr,
    input  logic [DATA_W-1:0]     wgt_data,
    output logic                  pe_reset,
    output logic                  pe_enable,
    output logic [DATA_W-1:0]     pe_floatA,
    output logic [DATA_W-1:0]     pe_floatB,
    input  logic [DATA_W-1:0]     pe_result,
    output logic [2:0]            dbg_state,
    pe_operand_sequencer_if.master out_if
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_FETCH  = 3'd2,
        S_DRAIN  = 3'd3,
        S_OUTPUT = 3'd4,
        S_DONE   = 3'd5
    } state_e;

    localparam int DRAIN_W = $clog2(PE_LATENCY + 1) + 1;
    localparam logic [ACT_ADDR_W-1:0] LAST_TERM  = ACT_ADDR_W'(NUM_TERMS - 1);
    localparam logic [6:0]            LAST_OUT   = 7'(NUM_OUTPUTS - 1);
    localparam logic [DRAIN_W-1:0]    DRAIN_LAST = DRAIN_W'(PE_LATENCY);

    state_e                state_q, state_d;
    logic [ACT_ADDR_W-1:0] term_q, term_d;
    logic [WGT_ADDR_W-1:0] wgt_addr_q, wgt_addr_d;
    logic [6:0]            out_idx_q, out_idx_d;
    logic [DRAIN_W-1:0]    drain_q, drain_d;
    logic [DATA_W-1:0]     out_data_q, out_data_d;
    logic                  pe_enable_q, pe_enable_d;
    logic                  rd_en;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            term_q      <= '0;
            wgt_addr_q  <= '0;
            out_idx_q   <= '0;
            drain_q     <= '0;
            out_data_q  <= '0;
            pe_enable_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            term_q      <= term_d;
            wgt_addr_q  <= wgt_addr_d;
            out_idx_q   <= out_idx_d;
            drain_q     <= drain_d;
            out_data_q  <= out_data_d;
            pe_enable_q <= pe_enable_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        term_d        = term_q;
        wgt_addr_d    = wgt_addr_q;
        out_idx_d     = out_idx_q;
        drain_d       = drain_q;
        out_data_d    = out_data_q;
        rd_en         = 1'b0;
        pe_reset      = 1'b0;
        busy          = 1'b1;
        done          = 1'b0;
        out_if.out_valid = 1'b0;

        case (state_q)
            S_IDLE: begin
                busy     = 1'b0;
                pe_reset = 1'b1;
                if (start) begin
                    state_d    = S_CLEAR;
                    out_idx_d  = '0;
                    wgt_addr_d = '0;
                end
            end
            S_CLEAR: begin
                pe_reset = 1'b1;
                term_d   = '0;
                state_d  = S_FETCH;
            end
            S_FETCH: begin
                rd_en      = 1'b1;
                term_d     = term_q + ACT_ADDR_W'(1);
                // Weight address keeps running across neurons: out_idx*NUM_TERMS + term without a multiplier.
                wgt_addr_d = wgt_addr_q + WGT_ADDR_W'(1);
                if (term_q == LAST_TERM) begin
                    state_d = S_DRAIN;
                    drain_d = '0;
                end
            end
            S_DRAIN: begin
                // One cycle for the memory return, PE_LATENCY more for the accumulator to settle.
                if (drain_q == DRAIN_LAST) begin
                    state_d    = S_OUTPUT;
                    out_data_d = pe_result;
                end else begin
                    drain_d = drain_q + DRAIN_W'(1);
                end
            end
            S_OUTPUT: begin
                out_if.out_valid = 1'b1;
                if (out_if.out_ready) begin
                    if (out_idx_q == LAST_OUT) begin
                        state_d = S_DONE;
                    end else begin
                        out_idx_d = out_idx_q + 7'd1;
                        state_d   = S_CLEAR;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Read data arrives one cycle after the strobe, so the PE enable is the strobe delayed by one.
    assign pe_enable_d = rd_en;

    assign act_rd_en = rd_en;
    assign wgt_rd_en = rd_en;
    assign act_addr  = term_q;
    assign wgt_addr  = wgt_addr_q;
    assign pe_enable = pe_enable_q;
    assign pe_floatA = pe_enable_q ? act_data : '0;
    assign pe_floatB = pe_enable_q ? wgt_data : '0;
    assign dbg_state = state_q;

    assign out_if.out_index = out_idx_q;
    assign out_if.out_data  = out_data_q;

endmodule

// File: tb/tb_pe_operand_sequencer.sv
// Directed bench for pe_operand_sequencer with a behavioural FP16 MAC PE and 1-cycle sync-read memories.
module tb_pe_operand_sequencer;

    localparam int DATA_W      = 16;
    localparam int NUM_TERMS   = 2;
    localparam int NUM_OUTPUTS = 2;
    localparam int ACT_ADDR_W  = 9;
    localparam int WGT_ADDR_W  = 16;
    localparam int PE_LATENCY  = 1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CLEAR  = 3'd1;
    localparam logic [2:0] ST_FETCH  = 3'd2;
    localparam logic [2:0] ST_DRAIN  = 3'd3;
    localparam logic [2:0] ST_OUTPUT = 3'd4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    always #5 clk = ~clk;

    logic                  busy, done, act_rd_en, wgt_rd_en;
    logic [ACT_ADDR_W-1:0] act_addr;
    logic [WGT_ADDR_W-1:0] wgt_addr;
    logic [DATA_W-1:0]     act_data, wgt_data;
    logic                  pe_reset, pe_enable;
    logic [DATA_W-1:0]     pe_floatA, pe_floatB, pe_result;
    logic [2:0]            dbg_state;

    pe_operand_sequencer_if #(.DATA_W(DATA_W)) out_if ();

    pe_operand_sequencer #(
        .DATA_W(DATA_W), .NUM_TERMS(NUM_TERMS), .NUM_OUTPUTS(NUM_OUTPUTS),
        .ACT_ADDR_W(ACT_ADDR_W), .WGT_ADDR_W(WGT_ADDR_W), .PE_LATENCY(PE_LATENCY)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .act_rd_en(act_rd_en), .act_addr(act_addr), .act_data(act_data),
        .wgt_rd_en(wgt_rd_en), .wgt_addr(wgt_addr), .wgt_data(wgt_data),
        .pe_reset(pe_reset), .pe_enable(pe_enable), .pe_floatA(pe_floatA),
        .pe_floatB(pe_floatB), .pe_result(pe_result), .dbg_state(dbg_state),
        .out_if(out_if.master)
    );

    // ---------------- FP16 helpers ----------------
    function automatic real pow2(input int n);
        real v;
        v = 1.0;
        if (n >= 0) for (int i = 0; i < n; i++) v = v * 2.0;
        else        for (int i = 0; i < -n; i++) v = v / 2.0;
        return v;
    endfunction

    function automatic real fp16_to_real(input logic [15:0] h);
        int  e;
        real m, v;
        e = int'(h[14:10]);
        m = real'(int'(h[9:0]));
        if (e == 0) v = m * pow2(-24);
        else        v = (m + 1024.0) * pow2(e - 25);
        return h[15] ? -v : v;
    endfunction

    function automatic logic [15:0] real_to_fp16(input real r);
        real  a;
        int   e, m;
        logic s;
        s = (r < 0.0);
        a = s ? -r : r;
        if (a < 6.2e-5) return {s, 15'd0};
        e = 0;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0)  begin a = a * 2.0; e--; end
        m = $rtoi(a * 1024.0 + 0.5);
        if (m >= 2048) begin m = 1024; e++; end
        if (e > 15) return {s, 5'h1f, 10'd0};
        return {s, 5'(e + 15), 10'(m - 1024)};
    endfunction

    function automatic int ulp_diff(input logic [15:0] a, input logic [15:0] b);
        if ($isunknown(a) || $isunknown(b)) return 99999;
        if (a[15] != b[15]) return 99999;
        return (a > b) ? int'(a - b) : int'(b - a);
    endfunction

    // ---------------- memories and PE ----------------
    logic [15:0] act_mem [0:NUM_TERMS-1];
    logic [15:0] wgt_mem [0:NUM_TERMS*NUM_OUTPUTS-1];
    logic [15:0] pe_acc;

    always @(posedge clk) begin
        if (act_rd_en) act_data <= (int'(act_addr) < NUM_TERMS) ? act_mem[act_addr[0]] : 16'h0;
        if (wgt_rd_en) wgt_data <= (int'(wgt_addr) < NUM_TERMS*NUM_OUTPUTS) ? wgt_mem[wgt_addr[1:0]] : 16'h0;
    end

    always @(posedge clk) begin
        if (pe_reset)       pe_acc <= 16'h0;
        else if (pe_enable) pe_acc <= real_to_fp16(fp16_to_real(pe_acc)
                                      + fp16_to_real(pe_floatA) * fp16_to_real(pe_floatB));
    end
    assign pe_result = pe_acc;

    // ---------------- monitor / scoreboard ----------------
    int          checks = 0;
    int          errors = 0;
    int          en_cnt, done_cnt, clear_err, stray_en, stray_op;
    logic [15:0] got_data[$];
    logic [6:0]  got_idx[$];
    int          got_en[$];
    logic [15:0] wgt_seq[$];
    logic [15:0] exp_q[$];
    logic [15:0] base0, base1;

    always @(negedge clk) begin
        if (reset) begin
            if (wgt_rd_en) wgt_seq.push_back(wgt_addr);
            if (pe_enable) en_cnt++;
            if (pe_enable && !(dbg_state == ST_FETCH || dbg_state == ST_DRAIN)) stray_en++;
            if (!pe_enable && (pe_floatA != 16'h0 || pe_floatB != 16'h0)) stray_op++;
            if (dbg_state == ST_CLEAR && !pe_reset) clear_err++;
            if (out_if.out_valid && out_if.out_ready) begin
                got_data.push_back(out_if.out_data);
                got_idx.push_back(out_if.out_index);
                got_en.push_back(en_cnt);
                en_cnt = 0;
            end
            if (done) done_cnt++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_mon();
        en_cnt = 0; done_cnt = 0; clear_err = 0; stray_en = 0; stray_op = 0;
        got_data.delete(); got_idx.delete(); got_en.delete(); wgt_seq.delete();
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input int maxc, output bit ok);
        int n;
        ok = 1'b0; n = 0;
        while (!ok && n < maxc) begin
            @(negedge clk);
            if (done === 1'b1) ok = 1'b1;
            n++;
        end
    endtask

    task automatic wait_state(input logic [2:0] st, input int maxc, output bit ok);
        int n;
        ok = 1'b0; n = 0;
        while (!ok && n < maxc) begin
            @(negedge clk);
            if (dbg_state === st) ok = 1'b1;
            n++;
        end
    endtask

    function automatic logic [15:0] qd(input int i);
        return (got_data.size() > i) ? got_data[i] : 16'hxxxx;
    endfunction

    function automatic logic [6:0] qi(input int i);
        return (got_idx.size() > i) ? got_idx[i] : 7'h7f;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        int bad;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, out_if.out_valid, pe_reset, pe_enable, act_rd_en, wgt_rd_en} !== 7'b0001000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 0001000",
                     {busy, done, out_if.out_valid, pe_reset, pe_enable, act_rd_en, wgt_rd_en});
        end
        checks++;
        if ({out_if.out_data, out_if.out_index, act_addr, wgt_addr, pe_floatA} !== '0) begin
            errors++;
            $display("FAIL reset_data: data=%h idx=%0d act_addr=%0d wgt_addr=%0d expected all zero",
                     out_if.out_data, out_if.out_index, act_addr, wgt_addr);
        end
        @(posedge clk); #1 reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            bad = 0;
            if ({busy, done, out_if.out_valid, pe_reset, pe_enable, act_rd_en} !== 6'b000100) bad++;
            if (dbg_state !== ST_IDLE) bad++;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL idle_hold cycle %0d: ctrl=%b state=%0d expected ctrl=000100 state=0",
                         c, {busy, done, out_if.out_valid, pe_reset, pe_enable, act_rd_en}, dbg_state);
            end
        end
    endtask

    task automatic check_results(input string tag);
        checks++;
        if (got_data.size() != NUM_OUTPUTS || qi(0) !== 7'd0 || qi(1) !== 7'd1) begin
            errors++;
            $display("FAIL %s_index: got n=%0d idx=%0d,%0d expected n=2 idx=0,1", tag, got_data.size(), qi(0), qi(1));
        end
        checks++;
        if (ulp_diff(qd(0), exp_q[0]) > 1) begin
            errors++;
            $display("FAIL %s_data0: got %h expected %h (+-1 ulp)", tag, qd(0), exp_q[0]);
        end
        checks++;
        if (ulp_diff(qd(1), exp_q[1]) > 1) begin
            errors++;
            $display("FAIL %s_data1: got %h expected %h (+-1 ulp)", tag, qd(1), exp_q[1]);
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL %s_done: got %0d done pulses expected 1", tag, done_cnt);
        end
    endtask

    task automatic test_basic_run();
        bit ok;
        int bad;
        clear_mon();
        @(posedge clk); #1 out_if.out_ready = 1'b1;
        pulse_start();
        wait_done(200, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL run_timeout: got no done expected done within 200 cycles"); end
        repeat (3) @(negedge clk);
        check_results("run");
        checks++;
        if (ulp_diff(qd(0), 16'h4DFB) > 1) begin
            errors++;
            $display("FAIL run_data0_const: got %h expected 4dfb (+-1 ulp)", qd(0));
        end
        base0 = qd(0);
        base1 = qd(1);
        checks++;
        if (got_en.size() != 2 || got_en[0] != NUM_TERMS || got_en[1] != NUM_TERMS) begin
            errors++;
            $display("FAIL run_enable_count: got n=%0d first=%0d expected 2 per neuron", got_en.size(),
                     (got_en.size() > 0) ? got_en[0] : -1);
        end
        bad = 0;
        for (int i = 0; i < 4; i++) if (wgt_seq.size() <= i || wgt_seq[i] !== 16'(i)) bad++;
        checks++;
        if (bad != 0 || wgt_seq.size() != 4) begin
            errors++;
            $display("FAIL run_wgt_addr: got n=%0d with %0d wrong expected sequence 0,1,2,3", wgt_seq.size(), bad);
        end
        checks++;
        if (clear_err != 0 || stray_en != 0 || stray_op != 0) begin
            errors++;
            $display("FAIL run_pe_ctrl: got clear_err=%0d stray_en=%0d stray_op=%0d expected 0,0,0",
                     clear_err, stray_en, stray_op);
        end
    endtask

    task automatic test_stall();
        bit          ok;
        int          bad;
        logic [15:0] hold_data;
        logic [6:0]  hold_idx;
        clear_mon();
        @(posedge clk); #1 out_if.out_ready = 1'b0;
        pulse_start();
        wait_state(ST_OUTPUT, 100, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL stall_reach: got state %0d expected OUTPUT", dbg_state); end
        hold_data = out_if.out_data;
        hold_idx  = out_if.out_index;
        checks++;
        if (hold_idx !== 7'd0 || ulp_diff(hold_data, exp_q[0]) > 1) begin
            errors++;
            $display("FAIL stall_first: got idx=%0d data=%h expected idx=0 data=%h", hold_idx, hold_data, exp_q[0]);
        end
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_if.out_valid !== 1'b1 || out_if.out_data !== hold_data ||
                out_if.out_index !== hold_idx || pe_enable !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stall_hold: got %0d unstable cycles expected 0", bad);
        end
        @(posedge clk); #1 out_if.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (dbg_state !== ST_CLEAR || out_if.out_valid !== 1'b0 || pe_reset !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: got state=%0d valid=%b expected state=1 valid=0", dbg_state, out_if.out_valid);
        end
        wait_done(200, ok);
        repeat (3) @(negedge clk);
        check_results("stall");
    endtask

    task automatic test_reset_midrun();
        bit ok;
        int n;
        clear_mon();
        out_if.out_ready = 1'b1;
        pulse_start();
        ok = 1'b0; n = 0;
        while (!ok && n < 100) begin
            @(negedge clk);
            if (dbg_state === ST_FETCH && out_if.out_index === 7'd1) ok = 1'b1;
            n++;
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL midrun_reach: got no FETCH of neuron 1 expected one"); end
        #1 reset = 1'b0;
        #1;
        checks++;
        if ({busy, done, out_if.out_valid, pe_reset, pe_enable, act_rd_en, wgt_rd_en} !== 7'b0001000 ||
            dbg_state !== ST_IDLE || out_if.out_index !== 7'd0 || out_if.out_data !== 16'h0 || wgt_addr !== '0) begin
            errors++;
            $display("FAIL midrun_reset: got ctrl=%b state=%0d idx=%0d wgt_addr=%0d expected 0001000/0/0/0",
                     {busy, done, out_if.out_valid, pe_reset, pe_enable, act_rd_en, wgt_rd_en},
                     dbg_state, out_if.out_index, wgt_addr);
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        clear_mon();
        pulse_start();
        wait_done(200, ok);
        repeat (3) @(negedge clk);
        check_results("restart");
        checks++;
        if (qd(0) !== base0 || qd(1) !== base1) begin
            errors++;
            $display("FAIL restart_same: got %h,%h expected %h,%h", qd(0), qd(1), base0, base1);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        clear_mon();
        out_if.out_ready = 1'b1;
        pulse_start();
        wait_state(ST_FETCH, 50, ok);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done(200, ok);
        repeat (20) @(negedge clk);
        checks++;
        if (done_cnt != 1 || busy !== 1'b0 || got_data.size() != NUM_OUTPUTS) begin
            errors++;
            $display("FAIL ignore_start: got done=%0d busy=%b outputs=%0d expected 1,0,2", done_cnt, busy, got_data.size());
        end
        clear_mon();
        @(posedge clk); #1 start = 1'b1;
        wait_done(200, ok);
        @(negedge clk);
        checks++;
        if (dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL held_idle: got state %0d expected 0", dbg_state);
        end
        @(negedge clk);
        checks++;
        if (dbg_state !== ST_CLEAR) begin
            errors++;
            $display("FAIL held_restart: got state %0d expected 1", dbg_state);
        end
        @(posedge clk); #1 start = 1'b0;
        wait_done(200, ok);
        repeat (3) @(negedge clk);
        checks++;
        if (done_cnt != 2 || got_data.size() != 4 || qi(2) !== 7'd0 || qi(3) !== 7'd1 ||
            qd(2) !== base0 || qd(3) !== base1) begin
            errors++;
            $display("FAIL held_b2b: got done=%0d n=%0d data2=%h data3=%h expected 2,4,%h,%h",
                     done_cnt, got_data.size(), qd(2), qd(3), base0, base1);
        end
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        out_if.out_ready = 1'b0;
        act_mem[0] = 16'h4000; act_mem[1] = 16'h459a;
        wgt_mem[0] = 16'h4200; wgt_mem[1] = 16'h4266;
        wgt_mem[2] = 16'hc866; wgt_mem[3] = 16'h40cd;
        for (int o = 0; o < NUM_OUTPUTS; o++)
            exp_q.push_back(real_to_fp16(
                fp16_to_real(act_mem[0]) * fp16_to_real(wgt_mem[o*NUM_TERMS]) +
                fp16_to_real(act_mem[1]) * fp16_to_real(wgt_mem[o*NUM_TERMS+1])));
        clear_mon();
        test_reset();
        test_basic_run();
        test_stall();
        test_reset_midrun();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
